pwm_drive_responder: RTL
========================

Name: pwm_drive_responder

Overview:
- Far end of the motor PWM request interface: accepts pwm_update/pwm_ratio/pwm_direction from the angle and speed controllers and drives the H-bridge PWM and direction pins.
- Loads new ratios only at period boundaries, so a pulse is never truncated.
- Acknowledges each applied ratio with a one-clock pwm_done pulse; upstream rising-edge detectors count these pulses as periods.

Parameters:
- PRESCALE, 8, clocks per PWM tick minus 1. Tick fires every PRESCALE+1 clocks.
- DEADTIME_PERIODS, 2, whole PWM periods the output is held low on a direction reversal. Used only with DEADTIME_EN.

Ports:
- clock  in  1  main clock
- reset_n  in  1  asynchronous active-low reset
- pwm_enable  in  1  0 forces IDLE and output low
- pwm_update  in  1  level; 1 = load pwm_ratio/pwm_direction at next boundary
- pwm_ratio  in  8  high-time out of 255
- pwm_direction  in  1  requested motor direction
- pwm_done  out  1  one-clock pulse: requested ratio now applied
- pwm_out  out  1  PWM pin, registered
- dir_out  out  1  direction pin, registered
- applied_ratio  out  8  duty currently in effect (readback)

Behaviour:
- Reset: all outputs 0, presc_cnt=0, period_cnt=0, deadtime counter=0, state IDLE. Reset applies immediately, including mid-period.
- Tick: presc_cnt counts 0..PRESCALE and wraps. tick=1 on the clock where presc_cnt==PRESCALE.
- Period: period_cnt advances 0..254 on tick (255 ticks per period).
- Boundary: tick && period_cnt==254.
- Duty: pwm_out <= (state==RUN) && (period_cnt < applied_ratio), registered, one-clock lag.
  - Ratio 0 keeps the output low.
  - Ratio 255 keeps the output continuously high.
- States:
  - IDLE:
    - pwm_out=0, counters held at 0, applied_ratio=0, dir_out holds its last value.
    - If pwm_enable && pwm_update: go to RUN next clock; load applied_ratio=pwm_ratio and dir_out=pwm_direction; pulse pwm_done; zero counters.
  - RUN, at each boundary:
    - pwm_update=1: load applied_ratio and dir_out; pwm_done=1 on the following clock only.
    - pwm_update=0: keep the existing duty; no pulse.
  - RUN, between boundaries: pwm_ratio changes are ignored.
  - BRAKE: exists only with DEADTIME_EN (see Optional Feature).
- pwm_update held high continuously gives exactly one pwm_done pulse per period.
- pwm_done is never high on two consecutive clocks.
- pwm_enable=0 in any state, synchronous:
  - next clock: state IDLE, pwm_out=0, applied_ratio=0, counters 0, no pwm_done pulse;
  - any pending load is dropped.
- pwm_enable rising with pwm_update=0: stay in IDLE.
- Simultaneous boundary and pwm_enable fall: disable wins, no pulse.
- Arithmetic: all compares unsigned 8-bit. presc_cnt is 8 bits; PRESCALE ≤ 255.

Optional Feature:
- Macro: DEADTIME_EN.
- Defined:
  - Trigger: a boundary load in RUN whose pwm_direction differs from dir_out.
  - On that load, enter BRAKE. applied_ratio=0, pwm_out low, dir_out unchanged.
  - Stay in BRAKE for DEADTIME_PERIODS full periods; the deadtime counter counts boundaries.
  - At the final BRAKE boundary: latch pwm_direction and pwm_ratio as sampled at that clock, return to RUN, pulse pwm_done.
  - No pwm_done is issued while in BRAKE.
  - IDLE→RUN loads direction immediately, with no brake.
  - pwm_enable=0 during BRAKE goes to IDLE.
- Undefined:
  - BRAKE state and its counter are not built.
  - Direction changes apply at the boundary like the ratio.

Test Plan:
- PRESCALE=0. Reset, enable=1, update=1, ratio=100 held → RUN; pwm_out high 100 clocks, low 155 clocks per 255-clock period; pwm_done pulses once every 255 clocks; applied_ratio=100.
- In RUN, change ratio 100→200 at mid-period → current period finishes at 100 high clocks; next period 200 high; pwm_done pulse one clock after that boundary.
- Ratio 0 then 255 → pwm_out constantly 0, then constantly 1 with no low glitch across the boundary.
- update=0 for 3 periods → duty unchanged, zero pwm_done pulses; update=1 again → pulse at the next boundary.
- Drop pwm_enable mid-period and mid-pulse → next clock pwm_out=0, applied_ratio=0, no pwm_done; re-enable with update=1 → immediate load and pulse.
- DEADTIME_EN, DEADTIME_PERIODS=2, dir 0→1 at ratio 150 → pwm_out low for 510 clocks, dir_out flips at the end of BRAKE, one pwm_done; without the macro dir_out flips at the first boundary with no gap.

Source files
------------

// File: rtl/pwm_drive_responder.sv
// pwm_drive_responder: receiving end of the motor PWM request interface.
// Drives the H-bridge PWM and direction pins and acknowledges every
// applied ratio with a one-clock pwm_done pulse. New ratios are taken
// only at period boundaries, so a pulse is never cut short.
// Optional build macro DEADTIME_EN adds a BRAKE state that holds the
// output low for DEADTIME_PERIODS whole periods on a direction reversal.
module pwm_drive_responder #(
  parameter int PRESCALE         = 8,  // clocks per PWM tick minus 1 (0..255)
  parameter int DEADTIME_PERIODS = 2   // brake length in periods (>= 1)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  input  logic       pwm_direction,
  output logic       pwm_done,
  output logic       pwm_out,
  output logic       dir_out,
  output logic [7:0] applied_ratio
);

  localparam logic [7:0] PRESCALE_C  = 8'(PRESCALE);
  localparam logic [7:0] PERIOD_LAST = 8'd254;  // 255 ticks per period

`ifdef DEADTIME_EN
  localparam logic [7:0] DEAD_LAST = 8'(DEADTIME_PERIODS - 1);

  typedef enum logic [1:0] {IDLE, RUN, BRAKE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t     state_reg, state_next;
  logic [7:0] presc_reg, presc_next;
  logic [7:0] period_reg, period_next;
  logic [7:0] applied_reg, applied_next;
  logic       dir_reg, dir_next;
  logic       done_reg, done_next;
  logic       pwm_reg, pwm_next;
`ifdef DEADTIME_EN
  logic [7:0] dead_reg, dead_next;
`endif

  logic       tick;
  logic       boundary;
  logic [7:0] presc_adv;
  logic [7:0] period_adv;

  // Free-running prescaler and period counter advance values.
  always_comb begin
    tick       = (presc_reg == PRESCALE_C);
    boundary   = tick && (period_reg == PERIOD_LAST);
    presc_adv  = tick ? 8'd0 : presc_reg + 8'd1;
    period_adv = period_reg;
    if (tick) begin
      period_adv = (period_reg == PERIOD_LAST) ? 8'd0 : period_reg + 8'd1;
    end
  end

  // Next-state and next-output logic; disable overrides everything last.
  always_comb begin
    state_next   = state_reg;
    presc_next   = presc_reg;
    period_next  = period_reg;
    applied_next = applied_reg;
    dir_next     = dir_reg;
    done_next    = 1'b0;
    pwm_next     = (state_reg == RUN) && (period_reg < applied_reg);
`ifdef DEADTIME_EN
    dead_next    = dead_reg;
`endif

    case (state_reg)
      IDLE: begin
        presc_next   = 8'd0;
        period_next  = 8'd0;
        applied_next = 8'd0;
        if (pwm_update) begin
          // First load after enable applies direction at once, no brake.
          state_next   = RUN;
          applied_next = pwm_ratio;
          dir_next     = pwm_direction;
          done_next    = 1'b1;
        end
      end

      RUN: begin
        presc_next  = presc_adv;
        period_next = period_adv;
        if (boundary && pwm_update) begin
`ifdef DEADTIME_EN
          if (pwm_direction != dir_reg) begin
            // Reversal: coast with the output low before flipping the bridge.
            state_next   = BRAKE;
            applied_next = 8'd0;
            dead_next    = 8'd0;
          end else begin
            applied_next = pwm_ratio;
            done_next    = 1'b1;
          end
`else
          applied_next = pwm_ratio;
          dir_next     = pwm_direction;
          done_next    = 1'b1;
`endif
        end
      end

`ifdef DEADTIME_EN
      BRAKE: begin
        presc_next   = presc_adv;
        period_next  = period_adv;
        applied_next = 8'd0;
        if (boundary) begin
          if (dead_reg == DEAD_LAST) begin
            // Brake over: take whatever is requested right now.
            state_next   = RUN;
            applied_next = pwm_ratio;
            dir_next     = pwm_direction;
            done_next    = 1'b1;
            dead_next    = 8'd0;
          end else begin
            dead_next = dead_reg + 8'd1;
          end
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase

    if (!pwm_enable) begin
      state_next   = IDLE;
      presc_next   = 8'd0;
      period_next  = 8'd0;
      applied_next = 8'd0;
      dir_next     = dir_reg;
      done_next    = 1'b0;
      pwm_next     = 1'b0;
`ifdef DEADTIME_EN
      dead_next    = 8'd0;
`endif
    end
  end

  // State and registered output update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      presc_reg   <= 8'd0;
      period_reg  <= 8'd0;
      applied_reg <= 8'd0;
      dir_reg     <= 1'b0;
      done_reg    <= 1'b0;
      pwm_reg     <= 1'b0;
`ifdef DEADTIME_EN
      dead_reg    <= 8'd0;
`endif
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      period_reg  <= period_next;
      applied_reg <= applied_next;
      dir_reg     <= dir_next;
      done_reg    <= done_next;
      pwm_reg     <= pwm_next;
`ifdef DEADTIME_EN
      dead_reg    <= dead_next;
`endif
    end
  end

  assign pwm_done      = done_reg;
  assign pwm_out       = pwm_reg;
  assign dir_out       = dir_reg;
  assign applied_ratio = applied_reg;

endmodule
